// File: rtl/sc_dec_pkg.sv
// sc_dec_pkg: shared state type, sizes and saturating normalization helper for sc_et_decoder
package sc_dec_pkg;
    typedef enum logic [1:0] {IDLE, COUNT, NORM, VALID} state_t;
    localparam int LEN_W = 64;
    localparam int LEN_LOG_W = $clog2(LEN_W + 1);
    typedef logic [LEN_W:0] wide_t;
    function automatic wide_t norm_sat(input wide_t ones, input int unsigned sh, input int unsigned lw, input int unsigned w);
        wide_t n, m;
        n = ones << sh;
        m = (wide_t'(1) << w) - wide_t'(1);
        return (|(n >> lw)) ? m : (n >> (lw - w)) & m;
    endfunction
endpackage

// File: rtl/sc_len_log2.sv
// sc_len_log2: floor(log2(len)) priority encoder with power-of-two flag
module sc_len_log2 #(
    parameter int LEN_W = 64,
    parameter int LOG_W = $clog2(LEN_W + 1)
) (
    input  logic [LEN_W:0]   len,
    output logic [LOG_W-1:0] k,
    output logic             pow2
);
    always_comb begin
        k = '0;
        for (int i = 0; i <= LEN_W; i++) if (len[i]) k = LOG_W'(i);
    end
    assign pow2 = $countones(len) == 1;
endmodule

// File: rtl/sc_et_decoder.sv
// sc_et_decoder: per-channel ones counting and power-of-two normalization of SC bitstreams
module sc_et_decoder #(
    parameter int WIDTH = 8,
    parameter int NUM_INPUTS = 8,
    parameter int LEN_W = WIDTH * NUM_INPUTS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          en,
    input  logic [NUM_INPUTS-1:0]         xs,
    input  logic                          done_in,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WIDTH*NUM_INPUTS-1:0]   results,
    output logic [$clog2(LEN_W+1)-1:0]    len_log2,
    output logic                          err
);
    import sc_dec_pkg::*;
    localparam int LOG_W = $clog2(LEN_W + 1);
    localparam logic [LEN_W:0] SAT = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] ONE = {{LEN_W{1'b0}}, 1'b1};
    state_t state, nxt;
    logic [LEN_W:0] len;
    logic [LOG_W-1:0] k;
    logic pow2, clr, cnt;
    logic [WIDTH*NUM_INPUTS-1:0] norm;
    assign clr = state == IDLE && start;
    assign cnt = state == COUNT && !done_in && en;
    assign out_valid = state == VALID;
    always_comb
        nxt = state == IDLE  ? (start ? COUNT : IDLE) :
              state == COUNT ? (done_in ? NORM : COUNT) :
              state == NORM  ? VALID :
              (out_ready ? IDLE : VALID);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= nxt;
    always_ff @(posedge clk)
        if (rst) len <= '0;
        else if (clr) len <= {{LEN_W{1'b0}}, en};
        else if (cnt && len != SAT) len <= len + ONE;
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
        logic [LEN_W:0] ones;
        always_ff @(posedge clk)
            if (rst) ones <= '0;
            else if (clr) ones <= {{LEN_W{1'b0}}, en & xs[i]};
            else if (cnt && xs[i] && ones != SAT) ones <= ones + ONE;
        assign norm[i*WIDTH +: WIDTH] = WIDTH'(norm_sat(wide_t'(ones), LEN_W - int'(k), LEN_W, WIDTH));
    end
    sc_len_log2 #(.LEN_W(LEN_W), .LOG_W(LOG_W)) u_len_log2 (.len(len), .k(k), .pow2(pow2));
    always_ff @(posedge clk)
        if (rst) begin
            results <= '0;
            len_log2 <= '0;
            err <= 1'b0;
        end else if (state == NORM) begin
            results <= norm;
            len_log2 <= k;
            err <= !pow2;
        end
endmodule

// File: tb/tb_sc_et_decoder.sv
// tb_sc_et_decoder: randomized streams against an arithmetic model of the decoder
module tb_sc_et_decoder;
    localparam int W = 2, N = 2, LW = 4, KW = 3;
    logic clk = 1'b0;
    logic rst, start, en, done_in, out_ready, out_valid, err;
    logic [N-1:0] xs;
    logic [W*N-1:0] results;
    logic [KW-1:0] len_log2;
    logic [W*N-1:0] e_res;
    logic [KW-1:0] e_k;
    logic e_err;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sc_et_decoder #(.WIDTH(W), .NUM_INPUTS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .xs(xs), .done_in(done_in),
        .out_ready(out_ready), .out_valid(out_valid), .results(results),
        .len_log2(len_log2), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int res_of(input int c, input int k);
        int nv;
        nv = c * (1 << (LW - k));
        return nv >= (1 << LW) ? (1 << W) - 1 : nv / (1 << (LW - W));
    endfunction

    task automatic stream(input int n, input int o0, input int o1, input bit gaps);
        logic [N:0] cyc[$];
        logic [N-1:0] b;
        int r0, r1, ln, k;
        r0 = o0;
        r1 = o1;
        if (n == 0 || (gaps && $urandom_range(0, 1) == 1)) cyc.push_back({1'b0, N'($urandom)});
        for (int j = 0; j < n; j++) begin
            if (gaps && j > 0) repeat ($urandom_range(0, 2)) cyc.push_back({1'b0, N'($urandom)});
            b[0] = $urandom_range(0, n - j - 1) < r0;
            b[1] = $urandom_range(0, n - j - 1) < r1;
            r0 -= int'(b[0]);
            r1 -= int'(b[1]);
            cyc.push_back({1'b1, b});
        end
        foreach (cyc[i]) begin
            start = (i == 0) || (gaps && $urandom_range(0, 3) == 0);
            {en, xs} = cyc[i];
            tick();
        end
        start = 0; done_in = 1; en = 1; xs = '1;
        tick();
        done_in = 0; en = 0; xs = '0;
        check("lat1", 32'(out_valid), 0);
        tick();
        check("valid", 32'(out_valid), 1);
        ln = n > 16 ? 16 : n;
        k = 0;
        while ((2 << k) <= ln) k++;
        e_k = KW'(k);
        e_err = ln == 0 || (ln & (ln - 1)) != 0;
        e_res = {W'(res_of(o1 > 16 ? 16 : o1, k)), W'(res_of(o0 > 16 ? 16 : o0, k))};
        check("ch0", 32'(results[W-1:0]), 32'(e_res[W-1:0]));
        check("ch1", 32'(results[2*W-1:W]), 32'(e_res[2*W-1:W]));
        check("len_log2", 32'(len_log2), 32'(e_k));
        check("err", 32'(err), 32'(e_err));
    endtask

    task automatic release_out(input bit hold);
        if (hold) for (int i = 0; i < 3; i++) begin
            out_ready = 0; start = 1; done_in = (i == 1); en = 1; xs = '1;
            tick();
            check("hold_v", 32'(out_valid), 1);
            check("hold_res", 32'(results), 32'(e_res));
            check("hold_k", 32'(len_log2), 32'(e_k));
            check("hold_err", 32'(err), 32'(e_err));
        end
        start = 0; done_in = 0; en = 0; xs = '0; out_ready = 1;
        tick();
        out_ready = 0;
        check("idle", 32'(out_valid), 0);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; en = 0; xs = '0; done_in = 0; out_ready = 0;
        tick();
        tick();
        check("rst_v", 32'(out_valid), 0);
        check("rst_res", 32'(results), 0);
        check("rst_k", 32'(len_log2), 0);
        check("rst_err", 32'(err), 0);
        rst = 0;
        done_in = 1;
        tick();
        done_in = 0;
        tick();
        tick();
        check("idle_done", 32'(out_valid), 0);
        stream(16, 8, 4, 0);  release_out(1);
        stream(4, 2, 1, 0);   release_out(0);
        stream(16, 16, 0, 0); release_out(0);
        stream(1, 1, 0, 0);   release_out(0);
        stream(6, 3, 2, 0);   release_out(0);
        stream(0, 0, 0, 0);   release_out(1);
        start = 1; en = 1; xs = '1;
        tick();
        start = 0;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0; en = 0; xs = '0;
        check("abort_res", 32'(results), 0);
        check("abort_err", 32'(err), 0);
        done_in = 1;
        tick();
        done_in = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_v", 32'(out_valid), 0);
        end
        stream(16, 5, 9, 0);  release_out(0);
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(0, 20));
            stream(n, int'($urandom_range(0, n)), int'($urandom_range(0, n)), 1);
            release_out(bit'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
